croc_pad_ctrl: RTL and testbench



---
 rtl/croc_pkg.sv | 24 ++
 rtl/croc_pad_filter.sv | 58 +++++
 rtl/croc_pad_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_croc_pad_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/croc_pkg.sv
// Shared definitions for the croc peripheral slice: pad controller register
// offsets, limits and the bus response state type.
package croc_pkg;

  localparam int unsigned PadCtrlMaxPads = 32;

  // Pad controller register offsets (byte addresses, word aligned)
  localparam logic [5:0] PadCtrlDirOffset    = 6'h00;
  localparam logic [5:0] PadCtrlOutOffset    = 6'h04;
  localparam logic [5:0] PadCtrlInOffset     = 6'h08;
  localparam logic [5:0] PadCtrlRiseEnOffset = 6'h0C;
  localparam logic [5:0] PadCtrlFallEnOffset = 6'h10;
  localparam logic [5:0] PadCtrlStatusOffset = 6'h14;
  localparam logic [5:0] PadCtrlFilterOffset = 6'h18;
  localparam logic [5:0] PadCtrlOutSetOffset = 6'h1C;
  localparam logic [5:0] PadCtrlOutClrOffset = 6'h20;

  // Bus response tracker: a granted request is answered on the next cycle
  typedef enum logic {
    PadBusIdle,
    PadBusRespond
  } pad_bus_state_e;

endpackage

// File: rtl/croc_pad_filter.sv
// Per-pad input path: synchroniser, programmable glitch filter and
// single-cycle rise/fall pulses that coincide with the filtered value update.
module croc_pad_filter #(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned FilterW    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pad_i,
  input  logic [FilterW-1:0] thresh_i,
  output logic               filt_o,
  output logic               rise_o,
  output logic               fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic [FilterW-1:0]    cnt_q;
  logic                  filt_q;
  logic                  sync;
  logic                  commit;

  // Shift the raw pad value through the synchroniser chain
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pad_i};
    end
  end

  assign sync = sync_q[SyncStages-1];

  // A mismatch that has persisted past the threshold commits. Using >= lets a
  // threshold lowered mid-count take effect on the next mismatching cycle.
  assign commit = (sync != filt_q) && (cnt_q >= thresh_i);

  // Count consecutive mismatching cycles and update the filtered value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync == filt_q) begin
      cnt_q <= '0;
    end else if (commit) begin
      filt_q <= sync;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + FilterW'(1);
    end
  end

  assign filt_o = filt_q;
  assign rise_o = commit &  sync;
  assign fall_o = commit & ~sync;

endmodule

// File: rtl/croc_pad_ctrl.sv
// Register-programmable controller for general-purpose bidirectional pads:
// bus register file, per-pad input filtering, edge status and level IRQ.
module croc_pad_ctrl
  import croc_pkg::*;
#(
  parameter int unsigned NumPads    = 8,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned FilterW    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [5:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic               gnt_o,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic               err_o,
  input  logic [NumPads-1:0] pad_in_i,
  output logic [NumPads-1:0] pad_out_o,
  output logic [NumPads-1:0] pad_oe_o,
  output logic               irq_o
);

  pad_bus_state_e state_q, state_d;

  logic [NumPads-1:0] dir_q,     dir_d;
  logic [NumPads-1:0] out_q,     out_d;
  logic [NumPads-1:0] rise_en_q, rise_en_d;
  logic [NumPads-1:0] fall_en_q, fall_en_d;
  logic [NumPads-1:0] status_q,  status_d;
  logic [FilterW-1:0] filter_q,  filter_d;
  logic [31:0]        rdata_q,   rdata_d;
  logic               err_q,     err_d;
  logic               irq_q;

  logic [NumPads-1:0] filt, rise, fall, edge_set, w1c;
  logic [NumPads-1:0] wdata_pads;
  logic [5:0]         offset;
  logic               unused_bits;

  assign wdata_pads  = wdata_i[NumPads-1:0];
  assign offset      = {addr_i[5:2], 2'b00};
  assign unused_bits = ^{addr_i[1:0], wdata_i};

  // Zero-extend a pad-wide vector onto the 32-bit read bus
  function automatic logic [31:0] pad_zext(input logic [NumPads-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NumPads-1:0] = v;
    return r;
  endfunction

  function automatic logic [31:0] filter_zext(input logic [FilterW-1:0] v);
    logic [31:0] r;
    r = '0;
    r[FilterW-1:0] = v;
    return r;
  endfunction

  for (genvar i = 0; i < NumPads; i++) begin : g_pad
    croc_pad_filter #(
      .SyncStages (SyncStages),
      .FilterW    (FilterW)
    ) u_filter (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .pad_i    (pad_in_i[i]),
      .thresh_i (filter_q),
      .filt_o   (filt[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i])
    );
  end

  assign edge_set = (rise & rise_en_q) | (fall & fall_en_q);

  // Bus FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= PadBusIdle;
    else       state_q <= state_d;
  end

  // Bus FSM: every granted request is answered on the following cycle
  always_comb begin
    state_d = req_i ? PadBusRespond : PadBusIdle;
  end

  // Bus FSM: outputs
  always_comb begin
    gnt_o    = req_i;
    rvalid_o = (state_q == PadBusRespond);
  end

  // Register file next-state and read/error decode for the granted access
  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    dir_d     = dir_q;
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    filter_d  = filter_q;
    w1c       = '0;
    rdata_d   = '0;
    err_d     = 1'b0;
    if (req_i) begin
      case (offset)
        PadCtrlDirOffset: begin
          if (we_i) dir_d = wdata_pads;
          else      rdata_d = pad_zext(dir_q);
        end
        PadCtrlOutOffset: begin
          if (we_i) out_d = wdata_pads;
          else      rdata_d = pad_zext(out_q);
        end
        PadCtrlInOffset: begin
          if (we_i) err_d = 1'b1;
          else      rdata_d = pad_zext(filt);
        end
        PadCtrlRiseEnOffset: begin
          if (we_i) rise_en_d = wdata_pads;
          else      rdata_d = pad_zext(rise_en_q);
        end
        PadCtrlFallEnOffset: begin
          if (we_i) fall_en_d = wdata_pads;
          else      rdata_d = pad_zext(fall_en_q);
        end
        PadCtrlStatusOffset: begin
          if (we_i) w1c = wdata_pads;
          else      rdata_d = pad_zext(status_q);
        end
        PadCtrlFilterOffset: begin
          if (we_i) filter_d = wdata_i[FilterW-1:0];
          else      rdata_d = filter_zext(filter_q);
        end
        PadCtrlOutSetOffset: begin
          if (we_i) out_d = out_q | wdata_pads;
        end
        PadCtrlOutClrOffset: begin
          if (we_i) out_d = out_q & ~wdata_pads;
        end
        default: err_d = 1'b1;
      endcase
    end
    // A new edge outranks a simultaneous clear of the same bit
    status_d = (status_q & ~w1c) | edge_set;
  end

  // Register file, response and IRQ flops; reset also drops pending status
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dir_q     <= '0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      filter_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      out_q     <= out_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      filter_q  <= filter_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      irq_q     <= |status_q;
    end
  end

  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign irq_o     = irq_q;
  assign pad_oe_o  = dir_q;
  assign pad_out_o = out_q;

endmodule

// File: tb/tb_croc_pad_ctrl.sv
// Directed bench for croc_pad_ctrl: register table plus filter, edge, W1C
// and reset sequences with hand-computed expectations.
module tb_croc_pad_ctrl;

  localparam int unsigned NumPads = 8;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               req_i = 1'b0;
  logic               we_i = 1'b0;
  logic [5:0]         addr_i = '0;
  logic [31:0]        wdata_i = '0;
  logic               gnt_o;
  logic               rvalid_o;
  logic [31:0]        rdata_o;
  logic               err_o;
  logic [NumPads-1:0] pad_in_i = '0;
  logic [NumPads-1:0] pad_out_o;
  logic [NumPads-1:0] pad_oe_o;
  logic               irq_o;

  int checks = 0;
  int errors = 0;

  croc_pad_ctrl #(.NumPads(NumPads), .SyncStages(2), .FilterW(4)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .pad_in_i  (pad_in_i),
    .pad_out_o (pad_out_o),
    .pad_oe_o  (pad_oe_o),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_oe;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [5:0] addr, logic [31:0] wdata,
                              logic [31:0] rd, logic err, logic [7:0] oe,
                              logic [7:0] out);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rd; v.exp_err = err; v.exp_oe = oe; v.exp_out = out;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus access: drive on the falling edge, grant on the rising edge,
  // sample the response 1 time unit later.
  task automatic bus(input logic we, input logic [5:0] addr,
                     input logic [31:0] wdata, output logic rv,
                     output logic [31:0] rd, output logic er);
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
    @(posedge clk_i);
    #1;
    rv = rvalid_o; rd = rdata_o; er = err_o;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] wdata);
    logic rv, er;
    logic [31:0] rd;
    bus(1'b1, addr, wdata, rv, rd, er);
  endtask

  task automatic rd_check(input string name, input logic [5:0] addr,
                          input logic [31:0] exp);
    logic rv, er;
    logic [31:0] rd;
    bus(1'b0, addr, 32'h0, rv, rd, er);
    check(name, rd, exp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk_i);
  endtask

  initial begin
    logic rv, er;
    logic [31:0] rd;

    // ---------------- reset state ----------------
    cycles(3);
    #1;
    check("reset pad_oe",  32'(pad_oe_o), 32'h0);
    check("reset pad_out", 32'(pad_out_o), 32'h0);
    check("reset irq",     32'(irq_o), 32'h0);
    check("reset rvalid",  32'(rvalid_o), 32'h0);
    check("reset rdata",   rdata_o, 32'h0);
    check("reset err",     32'(err_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // ---------------- register table ----------------
    for (int a = 0; a <= 8; a++)
      vecs.push_back(mk(1'b0, 6'(a * 4), 32'h0, 32'h0, 1'b0, 8'h00, 8'h00));
    vecs.push_back(mk(1'b0, 6'h24, 32'h0,        32'h0,  1'b1, 8'h00, 8'h00));
    vecs.push_back(mk(1'b0, 6'h3C, 32'h0,        32'h0,  1'b1, 8'h00, 8'h00));
    vecs.push_back(mk(1'b1, 6'h00, 32'hFFFF_FF0F, 32'h0, 1'b0, 8'h0F, 8'h00));
    vecs.push_back(mk(1'b0, 6'h00, 32'h0,        32'h0F, 1'b0, 8'h0F, 8'h00));
    vecs.push_back(mk(1'b1, 6'h04, 32'hA5,       32'h0,  1'b0, 8'h0F, 8'hA5));
    vecs.push_back(mk(1'b1, 6'h1C, 32'h02,       32'h0,  1'b0, 8'h0F, 8'hA7));
    vecs.push_back(mk(1'b0, 6'h04, 32'h0,        32'hA7, 1'b0, 8'h0F, 8'hA7));
    vecs.push_back(mk(1'b1, 6'h20, 32'h81,       32'h0,  1'b0, 8'h0F, 8'h26));
    vecs.push_back(mk(1'b0, 6'h05, 32'h0,        32'h26, 1'b0, 8'h0F, 8'h26));
    vecs.push_back(mk(1'b0, 6'h1C, 32'h0,        32'h0,  1'b0, 8'h0F, 8'h26));
    vecs.push_back(mk(1'b0, 6'h20, 32'h0,        32'h0,  1'b0, 8'h0F, 8'h26));
    vecs.push_back(mk(1'b1, 6'h08, 32'hFF,       32'h0,  1'b1, 8'h0F, 8'h26));
    vecs.push_back(mk(1'b0, 6'h08, 32'h0,        32'h0,  1'b0, 8'h0F, 8'h26));
    vecs.push_back(mk(1'b1, 6'h28, 32'hFF,       32'h0,  1'b1, 8'h0F, 8'h26));
    vecs.push_back(mk(1'b1, 6'h18, 32'h1F,       32'h0,  1'b0, 8'h0F, 8'h26));
    vecs.push_back(mk(1'b0, 6'h18, 32'h0,        32'h0F, 1'b0, 8'h0F, 8'h26));
    vecs.push_back(mk(1'b1, 6'h18, 32'h0,        32'h0,  1'b0, 8'h0F, 8'h26));
    vecs.push_back(mk(1'b1, 6'h0C, 32'h08,       32'h0,  1'b0, 8'h0F, 8'h26));
    vecs.push_back(mk(1'b0, 6'h0C, 32'h0,        32'h08, 1'b0, 8'h0F, 8'h26));

    foreach (vecs[i]) begin
      bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, rv, rd, er);
      check($sformatf("vec%0d rvalid", i), 32'(rv), 32'h1);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d pad_oe", i), 32'(pad_oe_o), 32'(vecs[i].exp_oe));
      check($sformatf("vec%0d pad_out", i), 32'(pad_out_o), 32'(vecs[i].exp_out));
    end
    cycles(1);
    #1;
    check("rvalid idle", 32'(rvalid_o), 32'h0);

    // ---------------- FILTER=0 latency, rise edge, irq ----------------
    // Continuous IN reads: the response after edge k shows IN as of edge k-1.
    @(negedge clk_i);
    pad_in_i[3] = 1'b1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 6'h08;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk_i);
      #1;
      check($sformatf("lat0 IN edge%0d", k), rdata_o,
            (k == 4) ? 32'h08 : 32'h0);
      check($sformatf("lat0 irq edge%0d", k), 32'(irq_o),
            (k == 4) ? 32'h1 : 32'h0);
    end
    req_i = 1'b0;
    rd_check("status after rise", 6'h14, 32'h08);
    // W1C: status clears on the grant edge, irq one edge later
    bus(1'b1, 6'h14, 32'h08, rv, rd, er);
    check("irq held on clear edge", 32'(irq_o), 32'h1);
    @(posedge clk_i);
    #1;
    check("irq drops after clear", 32'(irq_o), 32'h0);

    // ---------------- FILTER=3 glitch suppression ----------------
    wr(6'h18, 32'h3);
    @(negedge clk_i);
    pad_in_i[0] = 1'b1;
    cycles(3);
    @(negedge clk_i);
    pad_in_i[0] = 1'b0;
    cycles(8);
    rd_check("glitch IN", 6'h08, 32'h08);
    rd_check("glitch status", 6'h14, 32'h0);

    // Stable change commits at edge 2+1+3 = 6
    @(negedge clk_i);
    pad_in_i[0] = 1'b1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 6'h08;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk_i);
      #1;
      if (k >= 6)
        check($sformatf("lat3 IN edge%0d", k), rdata_o,
              (k == 7) ? 32'h09 : 32'h08);
    end
    req_i = 1'b0;

    // ---------------- fall edge coinciding with W1C ----------------
    wr(6'h18, 32'h0);
    wr(6'h10, 32'h02);
    @(negedge clk_i);
    pad_in_i[1] = 1'b1;
    cycles(5);
    @(negedge clk_i);
    pad_in_i[1] = 1'b0;
    cycles(5);
    rd_check("status first fall", 6'h14, 32'h02);
    @(negedge clk_i);
    pad_in_i[1] = 1'b1;
    cycles(5);
    check("irq before collide", 32'(irq_o), 32'h1);
    @(negedge clk_i);
    pad_in_i[1] = 1'b0;            // filt falls on edge 3
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; addr_i = 6'h14; wdata_i = 32'h02;
    @(posedge clk_i);              // edge 3: fall and W1C together
    #1;
    req_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("irq after collide", 32'(irq_o), 32'h1);
    rd_check("status set wins", 6'h14, 32'h02);
    wr(6'h14, 32'h02);
    rd_check("status cleared", 6'h14, 32'h0);
    check("irq after plain clear", 32'(irq_o), 32'h0);

    // ---------------- reset with a read in flight ----------------
    @(negedge clk_i);
    pad_in_i[1] = 1'b1;
    cycles(4);
    @(negedge clk_i);
    pad_in_i[1] = 1'b0;            // pending fall edge sets status again
    cycles(5);
    check("irq pending before reset", 32'(irq_o), 32'h1);
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = 6'h00;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
    check("rst rvalid",  32'(rvalid_o), 32'h0);
    check("rst rdata",   rdata_o, 32'h0);
    check("rst err",     32'(err_o), 32'h0);
    check("rst pad_oe",  32'(pad_oe_o), 32'h0);
    check("rst pad_out", 32'(pad_out_o), 32'h0);
    check("rst irq",     32'(irq_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    rd_check("status after reset", 6'h14, 32'h0);
    rd_check("dir after reset", 6'h00, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
